// File: rtl/ysyx_210544_dcache_resp_if.sv
// Signal bundle between the memory stage, the dcache responder and the memory bus.
// The slave modport is the responder's view. The master modport is the environment's view.
interface ysyx_210544_dcache_resp_if;
    logic        i_dcache_req;
    logic [63:0] i_dcache_addr;
    logic        i_dcache_op;
    logic [3:0]  i_dcache_bytes;
    logic [63:0] i_dcache_wdata;
    logic        o_dcache_ack;
    logic [63:0] o_dcache_rdata;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [63:0] o_bus_addr;
    logic [63:0] o_bus_wdata;
    logic [7:0]  o_bus_wstrb;
    logic        i_bus_ack;
    logic [63:0] i_bus_rdata;

    modport slave (
        input  i_dcache_req, i_dcache_addr, i_dcache_op, i_dcache_bytes, i_dcache_wdata,
        output o_dcache_ack, o_dcache_rdata,
        output o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_wstrb,
        input  i_bus_ack, i_bus_rdata
    );

    modport master (
        output i_dcache_req, i_dcache_addr, i_dcache_op, i_dcache_bytes, i_dcache_wdata,
        input  o_dcache_ack, o_dcache_rdata,
        input  o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_wstrb,
        output i_bus_ack, i_bus_rdata
    );
endinterface

// File: rtl/ysyx_210544_dcache_resp.sv
// Dcache responder: turns one unaligned 1..8 byte load/store into one or two aligned bus beats
// and returns right-aligned, zero-extended read data with a one-cycle ack.
module ysyx_210544_dcache_resp #(
    parameter int BUS_BYTES = 8
) (
    input  logic clk,
    input  logic rst,
    ysyx_210544_dcache_resp_if.slave dc
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
    localparam logic [1:0] S_BEAT1 = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        armed_q, armed_d;
    logic [63:0] addr_q, addr_d;
    logic        op_q, op_d;
    logic [2:0]  bytes_q, bytes_d;
    logic [63:0] wdata_q, wdata_d;
    logic        split_q, split_d;
    logic [63:0] lo_q, lo_d;

    logic        accept;
    logic [2:0]  off;
    logic [6:0]  sh_lo;
    logic [6:0]  sh_hi;
    logic [15:0] strb_mask;
    logic [63:0] rd_mask;
    logic [63:0] beat_base;
    logic        unused_bytes_msb;

    assign unused_bytes_msb = dc.i_dcache_bytes[3];

    assign accept    = (state_q == S_IDLE) && dc.i_dcache_req && armed_q;
    assign off       = addr_q[2:0];
    assign sh_lo     = {1'b0, off, 3'b000};
    // Beat 1 is only reachable with off != 0, so sh_hi never reaches 64 there.
    assign sh_hi     = 7'd64 - sh_lo;
    assign strb_mask = (16'h00FF >> (3'd7 - bytes_q)) << off;
    assign rd_mask   = {64{1'b1}} >> {(3'd7 - bytes_q), 3'b000};
    assign beat_base = {addr_q[63:3], 3'b000};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        op_d    = op_q;
        bytes_d = bytes_q;
        wdata_d = wdata_q;
        split_d = split_q;
        lo_d    = lo_q;
        armed_d = armed_q;

        // A request must be seen low before another one is taken.
        if (!dc.i_dcache_req) begin
            armed_d = 1'b1;
        end else if (accept) begin
            armed_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = dc.i_dcache_addr;
                    op_d    = dc.i_dcache_op;
                    bytes_d = dc.i_dcache_bytes[2:0];
                    wdata_d = dc.i_dcache_wdata;
                    split_d = ({1'b0, dc.i_dcache_addr[2:0]} + {1'b0, dc.i_dcache_bytes[2:0]}) > 4'd7;
                    state_d = S_BEAT0;
                end
            end
            S_BEAT0: begin
                if (dc.i_bus_ack) begin
                    lo_d    = dc.i_bus_rdata >> sh_lo;
                    state_d = split_q ? S_BEAT1 : S_ACK;
                end
            end
            S_BEAT1: begin
                if (dc.i_bus_ack) begin
                    lo_d    = lo_q | (dc.i_bus_rdata << sh_hi);
                    state_d = S_ACK;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            armed_q <= 1'b1;
            addr_q  <= '0;
            op_q    <= 1'b0;
            bytes_q <= '0;
            wdata_q <= '0;
            split_q <= 1'b0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            bytes_q <= bytes_d;
            wdata_q <= wdata_d;
            split_q <= split_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        dc.o_bus_req      = 1'b0;
        dc.o_bus_we       = 1'b0;
        dc.o_bus_addr     = '0;
        dc.o_bus_wdata    = '0;
        dc.o_bus_wstrb    = '0;
        dc.o_dcache_ack   = 1'b0;
        dc.o_dcache_rdata = '0;
        case (state_q)
            S_BEAT0: begin
                dc.o_bus_req   = 1'b1;
                dc.o_bus_we    = op_q;
                dc.o_bus_addr  = beat_base;
                dc.o_bus_wdata = wdata_q << sh_lo;
                dc.o_bus_wstrb = op_q ? strb_mask[7:0] : 8'h00;
            end
            S_BEAT1: begin
                dc.o_bus_req   = 1'b1;
                dc.o_bus_we    = op_q;
                dc.o_bus_addr  = beat_base + 64'(BUS_BYTES);
                dc.o_bus_wdata = wdata_q >> sh_hi;
                dc.o_bus_wstrb = op_q ? strb_mask[15:8] : 8'h00;
            end
            S_ACK: begin
                dc.o_dcache_ack   = 1'b1;
                dc.o_dcache_rdata = op_q ? 64'd0 : (lo_q & rd_mask);
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ysyx_210544_dcache_resp.sv
// Self-checking bench: directed cases plus random accesses compared against a byte-level model.
module tb_ysyx_210544_dcache_resp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;

    ysyx_210544_dcache_resp_if dif ();

    ysyx_210544_dcache_resp #(.BUS_BYTES(8)) dut (
        .clk (clk),
        .rst (rst),
        .dc  (dif)
    );

    always #5 clk = ~clk;

    // Drives one access and plays the bus side; every expectation is built byte by byte.
    task automatic run_access(input string tag, input logic [63:0] a, input logic op,
                              input logic [3:0] nb4, input logic [63:0] wd,
                              input logic [63:0] rd0, input logic [63:0] rd1,
                              input int w0, input int w1, input int hold,
                              output logic [63:0] got);
        int off, nb, nbeats, j, p;
        int waits[2];
        logic [63:0] rdb[2];
        logic [63:0] exp_addr[2];
        logic [63:0] exp_wd[2];
        logic [7:0]  exp_st[2];
        logic [63:0] exp_rd;
        off = int'(a[2:0]);
        nb = int'(nb4[2:0]);
        nbeats = (off + nb > 7) ? 2 : 1;
        rdb[0] = rd0; rdb[1] = rd1;
        waits[0] = w0; waits[1] = w1;
        for (int b = 0; b < 2; b++) begin
            exp_addr[b] = {a[63:3], 3'b000} + 64'(8 * b);
            exp_wd[b] = '0;
            exp_st[b] = '0;
            for (int l = 0; l < 8; l++) begin
                j = 8 * b + l - off;
                if (j >= 0 && j < 8) begin
                    exp_wd[b][8*l +: 8] = wd[8*j +: 8];
                    if (op && j <= nb) exp_st[b][l] = 1'b1;
                end
            end
        end
        exp_rd = '0;
        if (!op) begin
            for (int i = 0; i <= nb; i++) begin
                p = off + i;
                exp_rd[8*i +: 8] = rdb[p / 8][8*(p % 8) +: 8];
            end
        end

        dif.i_dcache_req = 1'b1;
        dif.i_dcache_addr = a;
        dif.i_dcache_op = op;
        dif.i_dcache_bytes = nb4;
        dif.i_dcache_wdata = wd;
        @(negedge clk);
        // Request stays high but its payload is scrambled; only latched values may matter.
        dif.i_dcache_addr = {$urandom, $urandom};
        dif.i_dcache_op = 1'($urandom);
        dif.i_dcache_bytes = 4'($urandom);
        dif.i_dcache_wdata = {$urandom, $urandom};
        for (int b = 0; b < nbeats; b++) begin
            for (int c = 0; c <= waits[b]; c++) begin
                total += 6;
                if (dif.o_bus_req !== 1'b1) begin
                    bad++; $display("FAIL %s beat%0d bus_req got=%b exp=1", tag, b, dif.o_bus_req);
                end
                if (dif.o_bus_addr !== exp_addr[b]) begin
                    bad++; $display("FAIL %s beat%0d bus_addr got=%h exp=%h", tag, b, dif.o_bus_addr, exp_addr[b]);
                end
                if (dif.o_bus_we !== op) begin
                    bad++; $display("FAIL %s beat%0d bus_we got=%b exp=%b", tag, b, dif.o_bus_we, op);
                end
                if (dif.o_bus_wstrb !== exp_st[b]) begin
                    bad++; $display("FAIL %s beat%0d bus_wstrb got=%h exp=%h", tag, b, dif.o_bus_wstrb, exp_st[b]);
                end
                if (dif.o_bus_wdata !== exp_wd[b]) begin
                    bad++; $display("FAIL %s beat%0d bus_wdata got=%h exp=%h", tag, b, dif.o_bus_wdata, exp_wd[b]);
                end
                if (dif.o_dcache_ack !== 1'b0) begin
                    bad++; $display("FAIL %s beat%0d early_ack got=%b exp=0", tag, b, dif.o_dcache_ack);
                end
                if (c == waits[b]) begin
                    dif.i_bus_ack = 1'b1;
                    dif.i_bus_rdata = rdb[b];
                end
                @(negedge clk);
                dif.i_bus_ack = 1'b0;
                dif.i_bus_rdata = {$urandom, $urandom};
            end
        end
        got = dif.o_dcache_rdata;
        total += 3;
        if (dif.o_dcache_ack !== 1'b1) begin
            bad++; $display("FAIL %s ack got=%b exp=1", tag, dif.o_dcache_ack);
        end
        if (dif.o_dcache_rdata !== exp_rd) begin
            bad++; $display("FAIL %s rdata got=%h exp=%h", tag, dif.o_dcache_rdata, exp_rd);
        end
        if (dif.o_bus_req !== 1'b0) begin
            bad++; $display("FAIL %s bus_req_in_ack got=%b exp=0", tag, dif.o_bus_req);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            total += 2;
            if (dif.o_bus_req !== 1'b0) begin
                bad++; $display("FAIL %s rearm_hold%0d bus_req got=%b exp=0", tag, h, dif.o_bus_req);
            end
            if (dif.o_dcache_ack !== 1'b0) begin
                bad++; $display("FAIL %s rearm_hold%0d ack got=%b exp=0", tag, h, dif.o_dcache_ack);
            end
        end
        dif.i_dcache_req = 1'b0;
        @(negedge clk);
        total += 3;
        if (dif.o_dcache_ack !== 1'b0) begin
            bad++; $display("FAIL %s ack_width got=%b exp=0", tag, dif.o_dcache_ack);
        end
        if (dif.o_dcache_rdata !== 64'd0) begin
            bad++; $display("FAIL %s rdata_clear got=%h exp=0", tag, dif.o_dcache_rdata);
        end
        if (dif.o_bus_req !== 1'b0) begin
            bad++; $display("FAIL %s idle_bus_req got=%b exp=0", tag, dif.o_bus_req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({dif.o_dcache_ack, dif.o_dcache_rdata, dif.o_bus_req, dif.o_bus_we,
             dif.o_bus_addr, dif.o_bus_wdata, dif.o_bus_wstrb} !== '0) begin
            bad++; $display("FAIL reset_outputs got ack=%b rd=%h req=%b addr=%h exp=all zero",
                            dif.o_dcache_ack, dif.o_dcache_rdata, dif.o_bus_req, dif.o_bus_addr);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [63:0] got;
        run_access("ld_aligned", 64'h80000008, 1'b0, 4'd7, 64'h0, 64'h1122334455667788, 64'h0, 0, 0, 0, got);
        total++;
        if (got !== 64'h1122334455667788) begin
            bad++; $display("FAIL ld_aligned_value got=%h exp=1122334455667788", got);
        end
        run_access("lb", 64'h80000003, 1'b0, 4'd0, 64'h0, 64'h1122334455667788, 64'h0, 1, 0, 0, got);
        total++;
        if (got !== 64'h55) begin
            bad++; $display("FAIL lb_value got=%h exp=55", got);
        end
        run_access("sw_split", 64'h80000006, 1'b1, 4'd3, 64'hAABBCCDD, 64'h0, 64'h0, 0, 2, 0, got);
        total++;
        if (got !== 64'h0) begin
            bad++; $display("FAIL sw_split_rdata got=%h exp=0", got);
        end
        run_access("lh_split", 64'h80000007, 1'b0, 4'd1, 64'h0, 64'h1100000000000000, 64'h22, 0, 0, 0, got);
        total++;
        if (got !== 64'h2211) begin
            bad++; $display("FAIL lh_split_value got=%h exp=2211", got);
        end
        run_access("wrap_top", 64'hFFFFFFFFFFFFFFFC, 1'b0, 4'd7, 64'h0,
                   64'h8877665544332211, 64'hFFEEDDCCBBAA9988, 0, 0, 0, got);
    endtask

    task automatic test_rearm();
        logic [63:0] got;
        run_access("rearm_first", 64'h80000010, 1'b0, 4'd3, 64'h0, 64'h0123456789ABCDEF, 64'h0, 0, 0, 3, got);
        run_access("rearm_second", 64'h80000020, 1'b1, 4'd7, 64'h0102030405060708, 64'h0, 64'h0, 1, 0, 0, got);
    endtask

    task automatic test_reset_mid();
        logic [63:0] got;
        dif.i_dcache_req = 1'b1;
        dif.i_dcache_addr = 64'h8000000E;
        dif.i_dcache_op = 1'b0;
        dif.i_dcache_bytes = 4'd3;
        dif.i_dcache_wdata = 64'h0;
        @(negedge clk);
        dif.i_bus_ack = 1'b1;
        dif.i_bus_rdata = 64'hDEADBEEF00000000;
        @(negedge clk);
        dif.i_bus_ack = 1'b0;
        total += 2;
        if (dif.o_bus_req !== 1'b1) begin
            bad++; $display("FAIL rstmid_beat1_req got=%b exp=1", dif.o_bus_req);
        end
        if (dif.o_bus_addr !== 64'h80000010) begin
            bad++; $display("FAIL rstmid_beat1_addr got=%h exp=80000010", dif.o_bus_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dif.i_dcache_req = 1'b0;
        total += 2;
        if (dif.o_bus_req !== 1'b0) begin
            bad++; $display("FAIL rstmid_req_drop got=%b exp=0", dif.o_bus_req);
        end
        if (dif.o_dcache_ack !== 1'b0) begin
            bad++; $display("FAIL rstmid_no_ack got=%b exp=0", dif.o_dcache_ack);
        end
        dif.i_bus_ack = 1'b1;
        dif.i_bus_rdata = 64'hFFFFFFFFFFFFFFFF;
        @(negedge clk);
        dif.i_bus_ack = 1'b0;
        @(negedge clk);
        total += 2;
        if (dif.o_bus_req !== 1'b0) begin
            bad++; $display("FAIL rstmid_late_ack_req got=%b exp=0", dif.o_bus_req);
        end
        if (dif.o_dcache_ack !== 1'b0) begin
            bad++; $display("FAIL rstmid_late_ack_ack got=%b exp=0", dif.o_dcache_ack);
        end
        run_access("rstmid_fresh", 64'h80000105, 1'b0, 4'd3, 64'h0,
                   64'hA1B2C3D4E5F60718, 64'h99887766554433CC, 0, 1, 0, got);
    endtask

    task automatic test_random();
        logic [63:0] got, a;
        logic [3:0] nb4;
        for (int n = 0; n < 80; n++) begin
            a = ($urandom_range(0, 7) == 0) ? {32'hFFFFFFFF, $urandom | 32'hFFFFFFC0}
                                            : {32'h0, 32'h80000000 | ($urandom & 32'h0000FFFF)};
            case ($urandom_range(0, 4))
                0: nb4 = 4'd0;
                1: nb4 = 4'd1;
                2: nb4 = 4'd3;
                3: nb4 = 4'd7;
                default: nb4 = 4'($urandom);
            endcase
            run_access("random", a, 1'($urandom), nb4, {$urandom, $urandom},
                       {$urandom, $urandom}, {$urandom, $urandom},
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), got);
        end
    endtask

    initial begin
        dif.i_dcache_req = 1'b0;
        dif.i_dcache_addr = '0;
        dif.i_dcache_op = 1'b0;
        dif.i_dcache_bytes = '0;
        dif.i_dcache_wdata = '0;
        dif.i_bus_ack = 1'b0;
        dif.i_bus_rdata = '0;
        test_reset();
        test_directed();
        test_rearm();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ysyx_210544_dcache_resp.md
Name: ysyx_210544_dcache_resp

Overview:
- Responder end of the dcache request/ack interface driven by the memory stage.
- Accepts one byte-addressed load or store of 1–8 bytes at any byte offset.
- Converts it into one or two 8-byte-aligned beats on a simple req/ack memory bus, with byte strobes on writes.
- Returns read data right-aligned and zero-extended, then pulses ack. Sign extension stays in the memory stage.

Parameters:
- BUS_BYTES, 8, data-bus width in bytes. Fixed at 8; beat alignment is addr[2:0].

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- i_dcache_req  in  1  request; level, held until o_dcache_ack
- i_dcache_addr  in  64  byte address
- i_dcache_op  in  1  0 = read, 1 = write
- i_dcache_bytes  in  4  access size minus one (0, 1, 3, 7 in use; any value 0..7 is handled generically; bit 3 ignored)
- i_dcache_wdata  in  64  write data, right-aligned
- o_dcache_ack  out  1  one-cycle completion pulse
- o_dcache_rdata  out  64  read result; valid while o_dcache_ack = 1
- o_bus_req  out  1  bus beat request; held until i_bus_ack
- o_bus_we  out  1  beat is a write
- o_bus_addr  out  64  beat address, addr[2:0] = 0
- o_bus_wdata  out  64  lane-positioned write data
- o_bus_wstrb  out  8  byte-lane write strobe; 0 on reads
- i_bus_ack  in  1  beat done; one-cycle pulse
- i_bus_rdata  in  64  beat read data; valid with i_bus_ack

Behaviour:
- States: IDLE, BEAT0, BEAT1, ACK.
- Reset: state = IDLE; armed = 1. o_dcache_ack, o_dcache_rdata, o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata and o_bus_wstrb are all 0.
- Accept: in IDLE, when i_dcache_req & armed:
  - latch addr, op, bytes[2:0] and wdata;
  - compute off = addr[2:0] and split = (off + bytes) > 7 (4-bit sum);
  - clear armed; go to BEAT0.
- Re-arm: armed returns to 1 on any cycle where i_dcache_req = 0. A req still held high in the cycle after ack never starts a second access.
- BEAT0:
  - o_bus_req = 1; o_bus_addr = {addr[63:3], 3'b0}; o_bus_we = op.
  - strobe mask m = (16'h00FF >> (7 - bytes)) << off (16-bit). o_bus_wstrb = op ? m[7:0] : 0.
  - o_bus_wdata = wdata << (8*off).
  - On i_bus_ack: capture lo = i_bus_rdata >> (8*off). Go to BEAT1 if split, else go to ACK.
- BEAT1:
  - o_bus_req = 1; o_bus_addr = {addr[63:3], 3'b0} + 8, wrapping mod 2^64.
  - o_bus_wstrb = op ? m[15:8] : 0.
  - o_bus_wdata = wdata >> (8*(8 - off)).
  - On i_bus_ack: merge lo |= i_bus_rdata << (8*(8 - off)); go to ACK.
- Back-to-back beats: o_bus_req stays high from BEAT0 into BEAT1. The bus treats req high in the cycle after ack as a new beat.
- ACK:
  - o_dcache_ack = 1 for exactly one cycle.
  - o_dcache_rdata = lo masked to (bytes+1)*8 bits, upper bits zero. On writes it is 0.
  - Next state is IDLE. o_dcache_rdata clears to 0 the following cycle.
- Bus outputs are 0 in IDLE and ACK.
- Latency: accept at cycle t puts bus req high at t+1. Bus ack in cycle k gives o_dcache_ack at k+1 for a non-split access. A split access adds the BEAT1 handshake.
- Zero-wait bus (ack in the first req cycle): non-split access acks at t+2, split at t+3.
- i_dcache_* inputs may change after accept without effect; only latched values are used.
- i_bus_ack outside BEAT0/BEAT1 is ignored.
- Reset mid-operation: next cycle state = IDLE, o_bus_req = 0, no o_dcache_ack, armed = 1. A late i_bus_ack is ignored.

Test Plan:
- Aligned LD read, addr 0x80000008, bytes 7; bus rdata 0x1122334455667788 -> one beat at 0x80000008, wstrb 0x00; o_dcache_rdata 0x1122334455667788; ack exactly one cycle after bus ack.
- LB read, addr 0x80000003, bytes 0; bus rdata 0x1122334455667788 -> o_dcache_rdata 0x0000000000000055; single beat.
- Split SW, addr 0x80000006, bytes 3, wdata 0xAABBCCDD -> beat0 addr 0x80000000, wstrb 0xC0, wdata 0xCCDD000000000000; beat1 addr 0x80000008, wstrb 0x03, wdata 0x000000000000AABB; o_bus_req continuous across both beats; one ack; rdata 0.
- Split LH read, addr 0x80000007; beat0 rdata 0x11000000_00000000, beat1 rdata 0x00000000_00000022 -> o_dcache_rdata 0x2211.
- Re-arm: i_dcache_req held high for 3 cycles after ack -> no new bus beat. Req low for 1 cycle then high -> new access accepted next cycle.
- Reset asserted while in BEAT1 with o_bus_req = 1 -> o_bus_req 0 next cycle; no o_dcache_ack; a subsequent i_bus_ack pulse is ignored; a fresh request then completes normally.
